// File: rtl/rr_arb_mux.sv
// rr_arb_mux
//   Round-robin N-to-1 valid/ready arbiter with packet locking and a single
//   registered output stage. One beat is accepted per cycle; once a port wins
//   with a non-final beat, the grant stays on that port until its s_last beat
//   is accepted. The winning beat is registered together with its port index.
//
// Ports
//   clk      : clock, all logic on posedge
//   rst      : synchronous, active-high reset
//   s_valid  : per-port beat valid              [N_PORTS-1:0]
//   s_data   : per-port payload                 [N_PORTS-1:0][WIDTH-1:0]
//   s_last   : per-port end-of-packet flag      [N_PORTS-1:0]
//   s_ready  : per-port accept (one-hot or zero) [N_PORTS-1:0]
//   m_valid  : output beat valid
//   m_data   : output payload                   [WIDTH-1:0]
//   m_last   : output end-of-packet
//   m_port   : source port of the output beat   [LOG_N-1:0]
//   m_ready  : downstream accept

module rr_arb_mux #(
    parameter int LOG_N   = 2,
    parameter int N_PORTS = 1 << LOG_N,
    parameter int WIDTH   = 32
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [N_PORTS-1:0]              s_valid,
    input  logic [N_PORTS-1:0][WIDTH-1:0]   s_data,
    input  logic [N_PORTS-1:0]              s_last,
    output logic [N_PORTS-1:0]              s_ready,
    output logic                            m_valid,
    output logic [WIDTH-1:0]                m_data,
    output logic                            m_last,
    output logic [LOG_N-1:0]                m_port,
    input  logic                            m_ready
);

    localparam int unsigned NP = N_PORTS;

    if (N_PORTS > (1 << LOG_N)) begin : g_bad_cfg
        $error("rr_arb_mux: N_PORTS must not exceed 1<<LOG_N");
    end

    typedef enum logic {
        ST_IDLE,
        ST_LOCKED
    } state_t;

    state_t             r_state;
    logic [LOG_N-1:0]   r_lock_port;
    logic [LOG_N-1:0]   r_last_sel;

    logic               r_m_valid;
    logic [WIDTH-1:0]   r_m_data;
    logic               r_m_last;
    logic [LOG_N-1:0]   r_m_port;

    logic               w_load;
    logic               w_grant_valid;
    logic [LOG_N-1:0]   w_grant;
    logic               w_accept;
    int unsigned        w_idx;

    assign m_valid = r_m_valid;
    assign m_data  = r_m_data;
    assign m_last  = r_m_last;
    assign m_port  = r_m_port;

    // Output register can take a new beat when empty or being drained.
    assign w_load = ~r_m_valid | m_ready;

    // Grant selection. While locked only the locked port is considered, even
    // if it is momentarily idle. Otherwise scan upward from the port after the
    // last completed packet, wrapping at N_PORTS. The sum last_sel+1+k never
    // reaches 2*N_PORTS, so one conditional subtract is enough to wrap.
    always_comb begin
        w_grant_valid = 1'b0;
        w_grant       = '0;
        w_idx         = 0;
        if (r_state == ST_LOCKED) begin
            if (s_valid[r_lock_port]) begin
                w_grant_valid = 1'b1;
                w_grant       = r_lock_port;
            end
        end else begin
            for (int unsigned k = 0; k < NP; k++) begin
                w_idx = 32'(r_last_sel) + 32'd1 + k;
                if (w_idx >= NP) begin
                    w_idx = w_idx - NP;
                end
                if (!w_grant_valid && s_valid[w_idx[LOG_N-1:0]]) begin
                    w_grant_valid = 1'b1;
                    w_grant       = w_idx[LOG_N-1:0];
                end
            end
        end
    end

    // A grant always refers to a valid port, so load & grant is an accept.
    assign w_accept = w_load & w_grant_valid & ~rst;

    always_comb begin
        s_ready = '0;
        for (int unsigned p = 0; p < NP; p++) begin
            s_ready[p] = w_accept & (w_grant == LOG_N'(p));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_lock_port <= '0;
            r_last_sel  <= LOG_N'(N_PORTS - 1);
            r_m_valid   <= 1'b0;
            r_m_data    <= '0;
            r_m_last    <= 1'b0;
            r_m_port    <= '0;
        end else begin
            if (w_load) begin
                r_m_valid <= w_accept;
                if (w_accept) begin
                    r_m_data <= s_data[w_grant];
                    r_m_last <= s_last[w_grant];
                    r_m_port <= w_grant;
                end
            end
            if (w_accept) begin
                if (s_last[w_grant]) begin
                    // Fairness advances only at packet boundaries.
                    r_state    <= ST_IDLE;
                    r_last_sel <= w_grant;
                end else if (r_state == ST_IDLE) begin
                    r_state     <= ST_LOCKED;
                    r_lock_port <= w_grant;
                end
            end
        end
    end

    a_ready_onehot: assert property (@(posedge clk) disable iff (rst)
        $onehot0(s_ready));

    a_out_hold: assert property (@(posedge clk) disable iff (rst)
        (r_m_valid && !m_ready) |=>
            ($stable(r_m_data) && $stable(r_m_last) && $stable(r_m_port)));

endmodule

// File: tb/tb_rr_arb_mux.sv
module tb_rr_arb_mux;

    localparam int NP = 4;
    localparam int LN = 2;
    localparam int W  = 32;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NP-1:0]         s_valid = '0;
    logic [NP-1:0][W-1:0]  s_data  = '0;
    logic [NP-1:0]         s_last  = '0;
    logic [NP-1:0]         s_ready;
    logic                  m_valid;
    logic [W-1:0]          m_data;
    logic                  m_last;
    logic [LN-1:0]         m_port;
    logic                  m_ready = 1'b0;

    rr_arb_mux #(.LOG_N(LN), .N_PORTS(NP), .WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
        .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_port(m_port),
        .m_ready(m_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] data;
        logic         last;
        int unsigned  gap;   // idle cycles before this beat is offered
    } beat_t;

    typedef struct {
        int           port;
        logic [W-1:0] data;
        logic         last;
    } exp_t;

    beat_t src_q[NP][$];     // per-producer pending beats
    exp_t  sb[$];            // expected output beats, in accept order
    int    port_log[$];      // observed m_port of every consumed beat

    // Reference model state
    int           mdl_last_sel;
    int           mdl_lock;    // -1 when no packet is open
    logic         mdl_mv;
    exp_t         mdl_out;

    int  total = 0;
    int  bad   = 0;
    bit  chk_rst = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int mdl_grant(input logic [NP-1:0] v);
        if (mdl_lock >= 0) return v[mdl_lock] ? mdl_lock : -1;
        for (int k = 1; k <= NP; k++) begin
            int p;
            p = (mdl_last_sel + k) % NP;
            if (v[p]) return p;
        end
        return -1;
    endfunction

    task automatic add_beat(input int p, input logic last, input int unsigned gap);
        beat_t b;
        b.data = {8'(p), 24'($urandom)};
        b.last = last;
        b.gap  = gap;
        src_q[p].push_back(b);
    endtask

    task automatic add_pkt(input int p, input int len);
        for (int i = 0; i < len; i++) add_beat(p, i == len - 1, 0);
    endtask

    task automatic tick(input logic mr);
        logic [NP-1:0]        v, l, er;
        logic [NP-1:0][W-1:0] d;
        beat_t                b;
        int                   g;
        logic                 load;
        exp_t                 e;
        @(negedge clk);
        rst = 1'b0;
        v = '0; l = '0; d = '0;
        for (int p = 0; p < NP; p++) begin
            if (src_q[p].size() > 0) begin
                b = src_q[p][0];
                if (b.gap > 0) begin
                    b.gap--;
                    src_q[p][0] = b;
                end else begin
                    v[p] = 1'b1; d[p] = b.data; l[p] = b.last;
                end
            end
        end
        s_valid = v; s_last = l; s_data = d; m_ready = mr;
        #1;
        if (chk_rst) begin
            chk("rst_m_port", m_port, 0);
            chk("rst_m_data", m_data, 0);
            chk("rst_m_last", m_last, 0);
            chk_rst = 0;
        end
        chk("m_valid", m_valid, mdl_mv);
        if (mdl_mv) begin
            chk("m_port_hold", m_port, mdl_out.port);
            chk("m_data_hold", m_data, mdl_out.data);
            chk("m_last_hold", m_last, mdl_out.last);
        end
        load = !mdl_mv || mr;
        g = mdl_grant(v);
        er = (load && g >= 0) ? NP'(1 << g) : '0;
        chk("s_ready", s_ready, er);
        if (load) mdl_mv = (g >= 0);
        if (load && g >= 0) begin
            e.port = g; e.data = d[g]; e.last = l[g];
            sb.push_back(e);
            mdl_out = e;
            void'(src_q[g].pop_front());
            if (l[g]) begin
                mdl_last_sel = g;
                mdl_lock = -1;
            end else begin
                mdl_lock = g;
            end
        end
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst = 1'b1; s_valid = '1; s_last = '1; m_ready = 1'b1;
            #1;
            chk("s_ready_in_rst", s_ready, 0);
        end
        mdl_last_sel = NP - 1;
        mdl_lock = -1;
        mdl_mv = 1'b0;
        sb.delete();
        for (int p = 0; p < NP; p++) src_q[p].delete();
        chk_rst = 1;
    endtask

    function automatic bit busy();
        bit b;
        b = mdl_mv || (sb.size() > 0);
        for (int p = 0; p < NP; p++) if (src_q[p].size() > 0) b = 1;
        return b;
    endfunction

    task automatic drain();
        int n;
        n = 0;
        while (busy() && n < 400) begin
            tick(1'b1);
            n++;
        end
        chk("drain_timeout", busy(), 0);
    endtask

    task automatic chk_log(input string nm, input int e[$]);
        chk({nm, "_len"}, port_log.size(), e.size());
        for (int i = 0; i < e.size() && i < port_log.size(); i++)
            chk(nm, port_log[i], e[i]);
        port_log.delete();
    endtask

    // Monitor: consumes a beat whenever the output handshake completes.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst && m_valid === 1'b1 && m_ready === 1'b1) begin
                port_log.push_back(int'(m_port));
                if (sb.size() == 0) begin
                    chk("sb_unexpected_beat", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("sb_port", m_port, e.port);
                    chk("sb_data", m_data, e.data);
                    chk("sb_last", m_last, e.last);
                end
            end
        end
    end

    initial begin
        mdl_last_sel = NP - 1;
        mdl_lock = -1;
        mdl_mv = 1'b0;

        // Reset, then round robin across single-beat packets
        do_reset(2);
        for (int r = 0; r < 2; r++)
            for (int p = 0; p < NP; p++) add_pkt(p, 1);
        drain();
        chk_log("rr_order", '{0, 1, 2, 3, 0, 1, 2, 3});

        // Packet lock: move last_sel to 0 first
        add_pkt(0, 1);
        drain();
        port_log.delete();
        add_pkt(1, 3); add_pkt(0, 1); add_pkt(2, 1);
        drain();
        chk_log("lock_order", '{1, 1, 1, 2, 0});

        // Locked producer pauses two cycles mid-packet
        add_beat(1, 1'b0, 0); add_beat(1, 1'b0, 2); add_beat(1, 1'b1, 0);
        add_pkt(0, 1); add_pkt(2, 1);
        drain();
        chk_log("lock_gap_order", '{1, 1, 1, 2, 0});

        // Backpressure on a port-3 stream
        add_pkt(3, 6);
        tick(1'b1); tick(1'b1);
        for (int i = 0; i < 4; i++) tick(1'b0);
        drain();
        chk_log("bp_order", '{3, 3, 3, 3, 3, 3});

        // Reset in the middle of a port-2 packet
        add_pkt(2, 4);
        tick(1'b1); tick(1'b1);
        do_reset(1);
        port_log.delete();
        add_pkt(0, 1); add_pkt(2, 1);
        drain();
        chk_log("post_rst_order", '{0, 2});

        // Random soak
        for (int c = 0; c < 10000; c++) begin
            for (int p = 0; p < NP; p++) begin
                if (src_q[p].size() == 0 && $urandom_range(0, 3) == 0) begin
                    int len;
                    len = $urandom_range(1, 4);
                    for (int i = 0; i < len; i++)
                        add_beat(p, i == len - 1,
                                 ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0);
                end
            end
            if ($urandom_range(0, 2999) == 0) do_reset(1);
            else tick($urandom_range(0, 3) != 0);
        end
        drain();
        chk("sb_empty_at_end", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
